// File: rtl/ddr3_cmd_monitor.sv
// Passive DDR3 command-bus monitor: decodes the controller's command pins, tracks
// per-bank open state and tRCD/tRP/tRFC timing, and flags protocol violations.
module ddr3_cmd_monitor #(
    parameter int NUM_BANKS = 8,
    parameter int T_RCD     = 4,
    parameter int T_RP      = 4,
    parameter int T_RFC     = 16
) (
    input  logic                         cpu_clk,
    input  logic                         reset,
    input  logic                         cs_n,
    input  logic                         ras_n,
    input  logic                         cas_n,
    input  logic                         we_n,
    input  logic [$clog2(NUM_BANKS)-1:0] ba,
    input  logic [15:0]                  addr,
    output logic                         cmd_valid,
    output logic [3:0]                   cmd_type,
    output logic [$clog2(NUM_BANKS)-1:0] cmd_ba,
    output logic [15:0]                  cmd_addr,
    output logic [NUM_BANKS-1:0]         bank_open,
    output logic                         err_valid,
    output logic [2:0]                   err_code,
    output logic [15:0]                  act_cnt,
    output logic [15:0]                  rd_cnt,
    output logic [15:0]                  wr_cnt
);

    localparam int BA_W  = $clog2(NUM_BANKS);
    localparam int RCD_W = $clog2(T_RCD + 1);
    localparam int RP_W  = $clog2(T_RP + 1);
    localparam int RFC_W = $clog2(T_RFC + 1);

    // A timer loaded at cycle n reaches zero exactly at cycle n + T.
    localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'(T_RCD - 1);
    localparam logic [RP_W-1:0]  RP_LOAD  = RP_W'(T_RP - 1);
    localparam logic [RFC_W-1:0] RFC_LOAD = RFC_W'(T_RFC - 1);

    localparam logic [3:0] CMD_NOP  = 4'd0;
    localparam logic [3:0] CMD_ACT  = 4'd1;
    localparam logic [3:0] CMD_RD   = 4'd2;
    localparam logic [3:0] CMD_WR   = 4'd3;
    localparam logic [3:0] CMD_PRE  = 4'd4;
    localparam logic [3:0] CMD_PREA = 4'd5;
    localparam logic [3:0] CMD_REF  = 4'd6;
    localparam logic [3:0] CMD_MRS  = 4'd7;
    localparam logic [3:0] CMD_ZQ   = 4'd8;

    // Open row is not kept: no output or check depends on it.
    logic [RCD_W-1:0] rcd_cnt [NUM_BANKS];
    logic [RP_W-1:0]  rp_cnt  [NUM_BANKS];
    logic [RFC_W-1:0] rfc_cnt;

    logic [3:0] dec_type;
    logic [2:0] dec_err;
    logic       is_rdwr;
    logic       ap_close;

    always_comb begin
        dec_type = CMD_NOP;
        if (!cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  dec_type = CMD_ACT;
                3'b101:  dec_type = CMD_RD;
                3'b100:  dec_type = CMD_WR;
                3'b010:  dec_type = addr[10] ? CMD_PREA : CMD_PRE;
                3'b001:  dec_type = CMD_REF;
                3'b000:  dec_type = CMD_MRS;
                3'b110:  dec_type = CMD_ZQ;
                default: dec_type = CMD_NOP;
            endcase
        end
    end

    assign is_rdwr  = (dec_type == CMD_RD) || (dec_type == CMD_WR);
    assign ap_close = is_rdwr && addr[10];

    // Checks run against state from earlier cycles; first match wins.
    always_comb begin
        dec_err = 3'd0;
        if (dec_type != CMD_NOP && rfc_cnt != '0)
            dec_err = 3'd1;
        else if (dec_type == CMD_ACT && rp_cnt[ba] != '0)
            dec_err = 3'd2;
        else if (dec_type == CMD_ACT && bank_open[ba])
            dec_err = 3'd3;
        else if (is_rdwr && !bank_open[ba])
            dec_err = 3'd4;
        else if (is_rdwr && rcd_cnt[ba] != '0)
            dec_err = 3'd5;
        else if (dec_type == CMD_REF && |bank_open)
            dec_err = 3'd6;
    end

    // NOTE: timer arrays are reset explicitly; they gate error checks right after reset.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
            cmd_ba    <= '0;
            cmd_addr  <= '0;
            err_valid <= 1'b0;
            err_code  <= 3'd0;
            act_cnt   <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            bank_open <= '0;
            rfc_cnt   <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                rcd_cnt[b] <= '0;
                rp_cnt[b]  <= '0;
            end
        end else begin
            cmd_valid <= (dec_type != CMD_NOP);
            cmd_type  <= dec_type;
            err_valid <= (dec_err != 3'd0);
            err_code  <= dec_err;
            if (dec_type != CMD_NOP) begin
                cmd_ba   <= ba;
                cmd_addr <= addr;
            end

            if (dec_type == CMD_ACT && act_cnt != 16'hFFFF) act_cnt <= act_cnt + 16'd1;
            if (dec_type == CMD_RD  && rd_cnt  != 16'hFFFF) rd_cnt  <= rd_cnt  + 16'd1;
            if (dec_type == CMD_WR  && wr_cnt  != 16'hFFFF) wr_cnt  <= wr_cnt  + 16'd1;

            if (dec_type == CMD_REF)
                rfc_cnt <= RFC_LOAD;
            else if (rfc_cnt != '0)
                rfc_cnt <= rfc_cnt - RFC_W'(1);

            for (int b = 0; b < NUM_BANKS; b++) begin
                if (dec_type == CMD_ACT && ba == BA_W'(b)) begin
                    bank_open[b] <= 1'b1;
                    rcd_cnt[b]   <= RCD_LOAD;
                end else if (rcd_cnt[b] != '0) begin
                    rcd_cnt[b] <= rcd_cnt[b] - RCD_W'(1);
                end

                if (dec_type == CMD_PREA ||
                    ((dec_type == CMD_PRE || ap_close) && ba == BA_W'(b))) begin
                    bank_open[b] <= 1'b0;
                    rp_cnt[b]    <= RP_LOAD;
                end else if (rp_cnt[b] != '0) begin
                    rp_cnt[b] <= rp_cnt[b] - RP_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ddr3_cmd_monitor.sv
// Self-checking bench for ddr3_cmd_monitor: directed boundary cases plus random
// traffic, checked against a timestamp-based reference model.
module tb_ddr3_cmd_monitor;

    localparam int NB    = 8;
    localparam int T_RCD = 4;
    localparam int T_RP  = 4;
    localparam int T_RFC = 16;

    typedef enum int {K_NOP, K_ACT, K_RD, K_WR, K_PRE, K_PREA, K_REF, K_MRS, K_ZQ} kind_t;

    logic        cpu_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        cs_n    = 1'b1;
    logic        ras_n   = 1'b1;
    logic        cas_n   = 1'b1;
    logic        we_n    = 1'b1;
    logic [2:0]  ba      = '0;
    logic [15:0] addr    = '0;

    logic        cmd_valid;
    logic [3:0]  cmd_type;
    logic [2:0]  cmd_ba;
    logic [15:0] cmd_addr;
    logic [7:0]  bank_open;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [15:0] act_cnt;
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;

    ddr3_cmd_monitor #(
        .NUM_BANKS(NB), .T_RCD(T_RCD), .T_RP(T_RP), .T_RFC(T_RFC)
    ) dut (
        .cpu_clk  (cpu_clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .ras_n    (ras_n),
        .cas_n    (cas_n),
        .we_n     (we_n),
        .ba       (ba),
        .addr     (addr),
        .cmd_valid(cmd_valid),
        .cmd_type (cmd_type),
        .cmd_ba   (cmd_ba),
        .cmd_addr (cmd_addr),
        .bank_open(bank_open),
        .err_valid(err_valid),
        .err_code (err_code),
        .act_cnt  (act_cnt),
        .rd_cnt   (rd_cnt),
        .wr_cnt   (wr_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: remembers when things happened, not countdown timers.
    int      cyc;
    int      last_act [NB];
    int      last_pre [NB];
    int      last_ref;
    bit [7:0] m_open;
    int      m_act, m_rd, m_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc      = 0;
        last_ref = -1000;
        m_open   = '0;
        m_act    = 0;
        m_rd     = 0;
        m_wr     = 0;
        for (int i = 0; i < NB; i++) begin
            last_act[i] = -1000;
            last_pre[i] = -1000;
        end
    endtask

    task automatic do_reset(input bit act_on_pins);
        reset = 1'b1;
        if (act_on_pins) begin
            {cs_n, ras_n, cas_n, we_n} = 4'b0011;
            ba   = 3'd3;
            addr = 16'h1234;
        end else begin
            {cs_n, ras_n, cas_n, we_n} = 4'b1111;
        end
        @(posedge cpu_clk);
        #1;
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_type", cmd_type, 0);
        check("rst_cmd_ba", cmd_ba, 0);
        check("rst_cmd_addr", cmd_addr, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_err_code", err_code, 0);
        check("rst_bank_open", bank_open, 0);
        check("rst_cnts", {act_cnt, rd_cnt}, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        reset = 1'b0;
        {cs_n, ras_n, cas_n, we_n} = 4'b1111;
        model_reset();
    endtask

    task automatic issue(input kind_t k, input int b, input logic [15:0] a);
        logic [15:0] aa = a;
        int          err = 0;
        bit          rdwr;
        if (k == K_PRE)  aa[10] = 1'b0;
        if (k == K_PREA) aa[10] = 1'b1;
        case (k)
            K_NOP:   {cs_n, ras_n, cas_n, we_n} = $urandom_range(0, 1) ?
                         4'b0111 : (4'b1000 | 4'($urandom_range(0, 7)));
            K_ACT:   {cs_n, ras_n, cas_n, we_n} = 4'b0011;
            K_RD:    {cs_n, ras_n, cas_n, we_n} = 4'b0101;
            K_WR:    {cs_n, ras_n, cas_n, we_n} = 4'b0100;
            K_PRE,
            K_PREA:  {cs_n, ras_n, cas_n, we_n} = 4'b0010;
            K_REF:   {cs_n, ras_n, cas_n, we_n} = 4'b0001;
            K_MRS:   {cs_n, ras_n, cas_n, we_n} = 4'b0000;
            default: {cs_n, ras_n, cas_n, we_n} = 4'b0110;
        endcase
        ba   = 3'(b);
        addr = aa;

        rdwr = (k == K_RD) || (k == K_WR);
        if (k != K_NOP && cyc - last_ref < T_RFC)               err = 1;
        else if (k == K_ACT && cyc - last_pre[b] < T_RP)        err = 2;
        else if (k == K_ACT && m_open[b])                       err = 3;
        else if (rdwr && !m_open[b])                            err = 4;
        else if (rdwr && cyc - last_act[b] < T_RCD)             err = 5;
        else if (k == K_REF && m_open != 0)                     err = 6;

        if (k == K_ACT) begin m_open[b] = 1'b1; last_act[b] = cyc; end
        if ((rdwr && aa[10]) || k == K_PRE) begin m_open[b] = 1'b0; last_pre[b] = cyc; end
        if (k == K_PREA) begin
            m_open = '0;
            for (int i = 0; i < NB; i++) last_pre[i] = cyc;
        end
        if (k == K_REF) last_ref = cyc;
        if (k == K_ACT && m_act < 65535) m_act++;
        if (k == K_RD  && m_rd  < 65535) m_rd++;
        if (k == K_WR  && m_wr  < 65535) m_wr++;

        @(posedge cpu_clk);
        #1;
        check("cmd_valid", cmd_valid, (k != K_NOP));
        check("cmd_type", cmd_type, k);
        if (k != K_NOP) check("cmd_ba_addr", {cmd_ba, cmd_addr}, {3'(b), aa});
        check("err_valid", err_valid, (err != 0));
        check("err_code", err_code, err);
        check("bank_open", bank_open, m_open);
        check("act_cnt", act_cnt, m_act);
        check("rd_cnt", rd_cnt, m_rd);
        check("wr_cnt", wr_cnt, m_wr);
        cyc++;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(K_NOP, 0, 16'h0);
    endtask

    initial begin
        model_reset();
        do_reset(1'b0);

        // Legal bank-0 sequence: ACT@10, WR@14, RD@20, PRE@25, ACT@29.
        nops(10);
        issue(K_ACT, 0, 16'h0012);
        nops(3);
        issue(K_WR, 0, 16'h0000);
        check("legal_wr_clean", err_valid, 0);
        nops(5);
        issue(K_RD, 0, 16'h0000);
        nops(4);
        issue(K_PRE, 0, 16'h0000);
        check("legal_pre_closed", bank_open, 8'h00);
        nops(3);
        issue(K_ACT, 0, 16'h0012);
        check("legal_act2", {err_valid, bank_open}, {1'b0, 8'h01});
        check("legal_counts", {act_cnt, rd_cnt}, {16'd2, 16'd1});
        check("legal_wr_count", wr_cnt, 16'd1);

        // tRCD boundary on bank 3.
        do_reset(1'b0);
        issue(K_ACT, 3, 16'h0040);
        nops(2);
        issue(K_RD, 3, 16'h0000);
        check("rcd_early", {err_valid, err_code}, {1'b1, 3'd5});
        do_reset(1'b0);
        issue(K_ACT, 3, 16'h0040);
        nops(3);
        issue(K_RD, 3, 16'h0000);
        check("rcd_exact", {err_valid, err_code}, {1'b0, 3'd0});

        // Open/closed violations.
        do_reset(1'b0);
        issue(K_ACT, 2, 16'h0007);
        nops(9);
        issue(K_ACT, 2, 16'h0008);
        check("act_open_bank", err_code, 3'd3);
        issue(K_WR, 5, 16'h0000);
        check("wr_closed_bank", err_code, 3'd4);
        issue(K_REF, 0, 16'h0000);
        check("ref_bank_open", err_code, 3'd6);

        // Refresh and precharge timing.
        do_reset(1'b0);
        issue(K_PREA, 0, 16'h0000);
        nops(3);
        issue(K_REF, 0, 16'h0000);
        nops(5);
        issue(K_ACT, 1, 16'h0000);
        check("rfc_early", {err_valid, err_code}, {1'b1, 3'd1});
        do_reset(1'b0);
        issue(K_PREA, 0, 16'h0000);
        nops(3);
        issue(K_REF, 0, 16'h0000);
        nops(15);
        issue(K_ACT, 1, 16'h0000);
        check("rfc_exact", err_valid, 0);
        issue(K_PRE, 1, 16'h0000);
        nops(2);
        issue(K_ACT, 1, 16'h0000);
        check("rp_early", err_code, 3'd2);
        issue(K_PRE, 1, 16'h0000);
        nops(3);
        issue(K_ACT, 1, 16'h0000);
        check("rp_exact", err_valid, 0);
        nops(3);
        issue(K_RD, 1, 16'h0400);
        check("ap_closed", bank_open[1], 0);
        nops(2);
        issue(K_ACT, 1, 16'h0000);
        check("ap_rp_early", err_code, 3'd2);

        // Random traffic, NOP-biased, including mid-run resets.
        for (int r = 0; r < 3; r++) begin
            do_reset(r == 1);
            for (int i = 0; i < 1000; i++) begin
                int sel = $urandom_range(0, 15);
                issue(sel > 8 ? K_NOP : kind_t'(sel), $urandom_range(0, NB - 1), 16'($urandom));
            end
        end

        // Saturation of rd_cnt, then reset with ACT on the pins.
        do_reset(1'b0);
        issue(K_ACT, 0, 16'h0001);
        nops(4);
        for (int i = 0; i < 65540; i++) issue(K_RD, 0, 16'h0000);
        check("rd_saturated", rd_cnt, 16'hFFFF);
        do_reset(1'b1);
        issue(K_NOP, 0, 16'h0000);
        check("post_reset_closed", bank_open, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
